// File: rtl/cam_lum_tracker_pkg.sv
// cam_pkg: shared types and defaults for the luma tracker.
//   LUMA_W        - width of the brightness value
//   TH*_DEF/HYST  - default level boundaries and hysteresis half-width
//   lum_level_t   - the four brightness levels
//   classify_raw  - threshold-only classification, used when priming
package cam_pkg;

  localparam int LUMA_W   = 8;
  localparam int TH0_DEF  = 64;
  localparam int TH1_DEF  = 128;
  localparam int TH2_DEF  = 192;
  localparam int HYST_DEF = 8;

  typedef enum logic [1:0] {
    LUM_DARK   = 2'd0,
    LUM_DIM    = 2'd1,
    LUM_NORMAL = 2'd2,
    LUM_BRIGHT = 2'd3
  } lum_level_t;

  function automatic lum_level_t classify_raw(input logic [LUMA_W-1:0] luma,
                                              input logic [LUMA_W-1:0] th0,
                                              input logic [LUMA_W-1:0] th1,
                                              input logic [LUMA_W-1:0] th2);
    if (luma >= th2)      return LUM_BRIGHT;
    else if (luma >= th1) return LUM_NORMAL;
    else if (luma >= th0) return LUM_DIM;
    else                  return LUM_DARK;
  endfunction

endpackage

// File: rtl/cam_lum_tracker_if.sv
// cam_lum_tracker_if: level-change event port (valid/ready).
//   valid - event pending (master drives)
//   ready - consumer accepts on a clock edge while valid=1 (slave drives)
//   level - new brightness level carried by the event
//   luma  - smoothed luma that caused the level change
interface cam_lum_tracker_if;
  import cam_pkg::*;

  logic              valid;
  logic              ready;
  logic [1:0]        level;
  logic [LUMA_W-1:0] luma;

  modport master (output valid, output level, output luma, input ready);
  modport slave  (input valid, input level, input luma, output ready);
endinterface

// File: rtl/cam_lum_tracker_ema.sv
// cam_lum_ema: toggle-strobe sample detector and exponential moving average.
//   clk, rst_n  - clock, asynchronous active-low reset
//   color, upd  - sample value and its toggle strobe
//   smp         - a sample is taken on the coming edge (combinational)
//   luma_nxt    - luma value that will be registered on that edge
//   luma        - registered smoothed luma (accumulator >> SHIFT)
//   luma_vld    - luma was updated on the previous edge
//   luma_first  - that update was the priming sample
module cam_lum_ema
  import cam_pkg::*;
#(
  parameter int SHIFT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LUMA_W-1:0] color,
  input  logic              upd,
  output logic              smp,
  output logic [LUMA_W-1:0] luma_nxt,
  output logic [LUMA_W-1:0] luma,
  output logic              luma_vld,
  output logic              luma_first
);
  // Accumulator holds luma scaled by 2^SHIFT; it stays below 256*2^SHIFT.
  localparam int AW = LUMA_W + SHIFT;

  logic          upd_q, upd_d;
  logic          primed_q, primed_d;
  logic [AW-1:0] acc_q, acc_d;
  logic          vld_q, vld_d;
  logic          first_q, first_d;

  always_comb begin
    upd_d    = upd;
    smp      = upd ^ upd_q;
    acc_d    = acc_q;
    primed_d = primed_q;
    vld_d    = smp;
    first_d  = smp & ~primed_q;
    if (smp) begin
      if (!primed_q) begin
        acc_d    = AW'(color) << SHIFT;
        primed_d = 1'b1;
      end else begin
        acc_d = acc_q - (acc_q >> SHIFT) + AW'(color);
      end
    end
    luma_nxt = acc_d[AW-1:SHIFT];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_q    <= 1'b0;
      primed_q <= 1'b0;
      acc_q    <= '0;
      vld_q    <= 1'b0;
      first_q  <= 1'b0;
    end else begin
      upd_q    <= upd_d;
      primed_q <= primed_d;
      acc_q    <= acc_d;
      vld_q    <= vld_d;
      first_q  <= first_d;
    end
  end

  assign luma       = acc_q[AW-1:SHIFT];
  assign luma_vld   = vld_q;
  assign luma_first = first_q;

endmodule

// File: rtl/cam_lum_tracker.sv
// cam_lum_tracker: smooths the frame-average brightness and reports
// hysteretic four-level brightness changes as valid/ready events.
//   VGA_CLK, RST_N  - clock, asynchronous active-low reset
//   color, upd      - brightness sample and toggle strobe
//   evt             - event port (valid/ready/level/luma), master side
//   level, luma     - live level and smoothed luma
//   evt_ovf         - sticky: a pending event was overwritten before acceptance
//   luma_min/max, sample_cnt - statistics; built only when CAM_LUM_STATS_EN
//                    is defined, otherwise tied to 0
module cam_lum_tracker
  import cam_pkg::*;
#(
  parameter int SHIFT = 2,
  parameter int TH0   = TH0_DEF,
  parameter int TH1   = TH1_DEF,
  parameter int TH2   = TH2_DEF,
  parameter int HYST  = HYST_DEF
) (
  input  logic                VGA_CLK,
  input  logic                RST_N,
  input  logic [LUMA_W-1:0]   color,
  input  logic                upd,
  cam_lum_tracker_if.master   evt,
  output logic [1:0]          level,
  output logic [LUMA_W-1:0]   luma,
  output logic                evt_ovf,
  output logic [LUMA_W-1:0]   luma_min,
  output logic [LUMA_W-1:0]   luma_max,
  output logic [15:0]         sample_cnt
);

  logic              smp;
  logic [LUMA_W-1:0] luma_nxt;
  logic              luma_vld;
  logic              luma_first;

  cam_lum_ema #(.SHIFT(SHIFT)) u_ema (
    .clk        (VGA_CLK),
    .rst_n      (RST_N),
    .color      (color),
    .upd        (upd),
    .smp        (smp),
    .luma_nxt   (luma_nxt),
    .luma       (luma),
    .luma_vld   (luma_vld),
    .luma_first (luma_first)
  );

  function automatic logic [LUMA_W-1:0] th_of(input logic [1:0] idx);
    case (idx)
      2'd0:    return LUMA_W'(TH0);
      2'd1:    return LUMA_W'(TH1);
      default: return LUMA_W'(TH2);
    endcase
  endfunction

  logic [1:0]        level_q, level_d;
  logic              evt_valid_q, evt_valid_d;
  logic [1:0]        evt_level_q, evt_level_d;
  logic [LUMA_W-1:0] evt_luma_q, evt_luma_d;
  logic              evt_ovf_q, evt_ovf_d;
  logic              new_evt;
  logic [8:0]        up_sum, dn_diff;
  logic [LUMA_W-1:0] up_bound, dn_bound;

  // Boundaries around the current level, in 9 bits and clamped to 0..255.
  always_comb begin
    up_sum   = {1'b0, th_of(level_q)} + 9'(HYST);
    dn_diff  = {1'b0, th_of(level_q - 2'd1)} - 9'(HYST);
    up_bound = up_sum[8]  ? 8'hFF : up_sum[7:0];
    dn_bound = dn_diff[8] ? 8'h00 : dn_diff[7:0];
  end

  // Classification runs one edge after luma updates; at most one step per sample.
  always_comb begin
    level_d = level_q;
    new_evt = 1'b0;
    if (luma_vld) begin
      if (luma_first) begin
        level_d = classify_raw(luma, LUMA_W'(TH0), LUMA_W'(TH1), LUMA_W'(TH2));
        new_evt = 1'b1;
      end else if (level_q != 2'd3 && luma >= up_bound) begin
        level_d = level_q + 2'd1;
      end else if (level_q != 2'd0 && luma < dn_bound) begin
        level_d = level_q - 2'd1;
      end
      if (level_d != level_q) new_evt = 1'b1;
    end
  end

  // A new event always wins; it only counts as an overflow when the
  // pending one is not being accepted on the same edge.
  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_level_d = evt_level_q;
    evt_luma_d  = evt_luma_q;
    evt_ovf_d   = evt_ovf_q;
    if (new_evt) begin
      evt_valid_d = 1'b1;
      evt_level_d = level_d;
      evt_luma_d  = luma;
      if (evt_valid_q && !evt.ready) evt_ovf_d = 1'b1;
    end else if (evt_valid_q && evt.ready) begin
      evt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      level_q     <= 2'd0;
      evt_valid_q <= 1'b0;
      evt_level_q <= 2'd0;
      evt_luma_q  <= '0;
      evt_ovf_q   <= 1'b0;
    end else begin
      level_q     <= level_d;
      evt_valid_q <= evt_valid_d;
      evt_level_q <= evt_level_d;
      evt_luma_q  <= evt_luma_d;
      evt_ovf_q   <= evt_ovf_d;
    end
  end

  assign level     = level_q;
  assign evt_ovf   = evt_ovf_q;
  assign evt.valid = evt_valid_q;
  assign evt.level = evt_level_q;
  assign evt.luma  = evt_luma_q;

`ifdef CAM_LUM_STATS_EN
  // Statistics follow the luma value registered on the sample edge.
  logic [LUMA_W-1:0] luma_min_q, luma_min_d;
  logic [LUMA_W-1:0] luma_max_q, luma_max_d;
  logic [15:0]       sample_cnt_q, sample_cnt_d;

  always_comb begin
    luma_min_d   = luma_min_q;
    luma_max_d   = luma_max_q;
    sample_cnt_d = sample_cnt_q;
    if (smp) begin
      if (luma_nxt < luma_min_q) luma_min_d = luma_nxt;
      if (luma_nxt > luma_max_q) luma_max_d = luma_nxt;
      if (sample_cnt_q != 16'hFFFF) sample_cnt_d = sample_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      luma_min_q   <= 8'hFF;
      luma_max_q   <= 8'h00;
      sample_cnt_q <= 16'd0;
    end else begin
      luma_min_q   <= luma_min_d;
      luma_max_q   <= luma_max_d;
      sample_cnt_q <= sample_cnt_d;
    end
  end

  assign luma_min   = luma_min_q;
  assign luma_max   = luma_max_q;
  assign sample_cnt = sample_cnt_q;
`else
  logic stats_unused;
  assign stats_unused = ^{smp, luma_nxt};
  assign luma_min     = '0;
  assign luma_max     = '0;
  assign sample_cnt   = '0;
`endif

endmodule

// File: tb/tb_cam_lum_tracker.sv
module tb_cam_lum_tracker;
  import cam_pkg::*;

`ifdef CAM_LUM_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        VGA_CLK = 1'b0;
  logic        RST_N;
  logic [7:0]  color;
  logic        upd;
  logic [1:0]  level;
  logic [7:0]  luma;
  logic        evt_ovf;
  logic [7:0]  luma_min;
  logic [7:0]  luma_max;
  logic [15:0] sample_cnt;

  cam_lum_tracker_if evt_if ();

  cam_lum_tracker dut (
    .VGA_CLK    (VGA_CLK),
    .RST_N      (RST_N),
    .color      (color),
    .upd        (upd),
    .evt        (evt_if),
    .level      (level),
    .luma       (luma),
    .evt_ovf    (evt_ovf),
    .luma_min   (luma_min),
    .luma_max   (luma_max),
    .sample_cnt (sample_cnt)
  );

  always #5 VGA_CLK = ~VGA_CLK;

  typedef struct { int lvl; int luma; } evt_t;
  evt_t evt_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int n_evt    = 0;

  // Reference model, default parameters (SHIFT=2, bounds 64/128/192, HYST=8).
  int m_acc    = 0;
  int m_lvl    = 0;
  bit m_primed = 1'b0;
  int up_th[3] = '{72, 136, 200};
  int dn_th[4] = '{0, 56, 120, 184};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input int c);
    int l;
    int nl;
    @(negedge VGA_CLK);
    color = 8'(c);
    upd   = ~upd;
    if (!m_primed) begin
      m_acc    = c * 4;
      l        = m_acc / 4;
      nl       = (l >= 192) ? 3 : (l >= 128) ? 2 : (l >= 64) ? 1 : 0;
      m_primed = 1'b1;
      evt_q.push_back('{nl, l});
    end else begin
      m_acc = m_acc - m_acc / 4 + c;
      l     = m_acc / 4;
      nl    = m_lvl;
      if (m_lvl < 3 && l >= up_th[m_lvl])      nl = m_lvl + 1;
      else if (m_lvl > 0 && l < dn_th[m_lvl])  nl = m_lvl - 1;
      if (nl != m_lvl) evt_q.push_back('{nl, l});
    end
    m_lvl = nl;
    @(posedge VGA_CLK);
    #1;
    $display("sample color=%0d luma=%0d exp_level=%0d", c, luma, nl);
    check_val("luma_t1", 32'(luma), 32'(l));
  endtask

  // Choose the color that lands the model luma exactly on target.
  task automatic send_target(input int target);
    send(target * 4 - (m_acc - m_acc / 4));
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge VGA_CLK);
    #1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && evt_q.size() != 0; i++) @(posedge VGA_CLK);
    #2;
    check_val(tag, 32'(evt_q.size()), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_evt_valid"}, 32'(evt_if.valid), 32'd0);
    check_val({tag, "_evt_level"}, 32'(evt_if.level), 32'd0);
    check_val({tag, "_evt_luma"},  32'(evt_if.luma),  32'd0);
    check_val({tag, "_level"},     32'(level),        32'd0);
    check_val({tag, "_luma"},      32'(luma),         32'd0);
    check_val({tag, "_ovf"},       32'(evt_ovf),      32'd0);
    check_val({tag, "_min"},       32'(luma_min),     STATS ? 32'd255 : 32'd0);
    check_val({tag, "_max"},       32'(luma_max),     32'd0);
    check_val({tag, "_cnt"},       32'(sample_cnt),   32'd0);
  endtask

  // Event monitor: pops the scoreboard on every accepted event.
  initial begin
    evt_t e;
    forever begin
      @(negedge VGA_CLK);
      #1;
      if (RST_N && evt_if.valid && evt_if.ready) begin
        if (evt_q.size() == 0) begin
          check_val("evt_unexpected", 32'(evt_if.valid), 32'd0);
        end else begin
          e = evt_q.pop_front();
          n_evt++;
          $display("event level=%0d luma=%0d exp_level=%0d exp_luma=%0d",
                   evt_if.level, evt_if.luma, e.lvl, e.luma);
          check_val("evt_level", 32'(evt_if.level), 32'(e.lvl));
          check_val("evt_luma",  32'(evt_if.luma),  32'(e.luma));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    evt_t last;
    RST_N        = 1'b0;
    color        = 8'd0;
    upd          = 1'b0;
    evt_if.ready = 1'b1;
    repeat (3) @(posedge VGA_CLK);
    @(negedge VGA_CLK);
    #2;
    RST_N = 1'b1;

    // Idle with constant strobe: nothing happens.
    wait_cycles(100);
    check_reset_state("idle");

    // Prime with 200: BRIGHT event visible for exactly one cycle.
    send(200);
    wait_cycles(1);
    check_val("prime_valid", 32'(evt_if.valid), 32'd1);
    check_val("prime_level", 32'(level), 32'd3);
    wait_cycles(1);
    check_val("prime_valid_drop", 32'(evt_if.valid), 32'd0);
    drain("prime_drain");

    // Back-to-back samples of 100: events at 175 (level 2) and 118 (level 1).
    base = n_evt;
    for (int i = 0; i < 6; i++) send(100);
    drain("decay_drain");
    check_val("decay_evt_count", 32'(n_evt - base), 32'd2);
    check_val("decay_level", 32'(level), 32'(m_lvl));
    check_val("decay_luma", 32'(luma), 32'd118);

    // Hysteresis: plateau below 136 stays DIM, 136 exactly moves to NORMAL.
    base = n_evt;
    for (int i = 0; i < 10; i++) send(133);
    send_target(135);
    drain("hyst_hold_drain");
    check_val("hyst_hold_evt", 32'(n_evt - base), 32'd0);
    check_val("hyst_hold_level", 32'(level), 32'd1);
    send_target(136);
    drain("hyst_up_drain");
    check_val("hyst_up_evt", 32'(n_evt - base), 32'd1);
    check_val("hyst_up_level", 32'(level), 32'd2);

    // Two level changes while the consumer stalls: overwrite and sticky overflow.
    @(negedge VGA_CLK);
    evt_if.ready = 1'b0;
    for (int i = 0; i < 3; i++) send(255);
    send(0);
    wait_cycles(2);
    check_val("ovf_qsize", 32'(evt_q.size()), 32'd2);
    last = evt_q[$];
    check_val("ovf_valid", 32'(evt_if.valid), 32'd1);
    check_val("ovf_flag", 32'(evt_ovf), 32'd1);
    check_val("ovf_payload_level", 32'(evt_if.level), 32'(last.lvl));
    check_val("ovf_payload_luma", 32'(evt_if.luma), 32'(last.luma));
    evt_q.delete();
    evt_q.push_back(last);
    @(negedge VGA_CLK);
    evt_if.ready = 1'b1;
    drain("ovf_drain");
    wait_cycles(1);
    check_val("ovf_valid_clear", 32'(evt_if.valid), 32'd0);
    check_val("ovf_sticky", 32'(evt_ovf), 32'd1);

    // Reset while an event is pending, then re-prime with 50.
    @(negedge VGA_CLK);
    evt_if.ready = 1'b0;
    send(0);
    wait_cycles(1);
    check_val("pend_valid", 32'(evt_if.valid), 32'd1);
    @(posedge VGA_CLK);
    #3;
    RST_N = 1'b0;
    upd   = 1'b0;
    #1;
    evt_q.delete();
    m_primed = 1'b0;
    m_acc    = 0;
    m_lvl    = 0;
    check_reset_state("midrst");
    @(negedge VGA_CLK);
    #2;
    RST_N        = 1'b1;
    evt_if.ready = 1'b1;
    send(50);
    check_val("reprime_cnt", 32'(sample_cnt), STATS ? 32'd1 : 32'd0);
    check_val("reprime_min", 32'(luma_min), STATS ? 32'd50 : 32'd0);
    check_val("reprime_max", 32'(luma_max), STATS ? 32'd50 : 32'd0);
    wait_cycles(1);
    check_val("reprime_valid", 32'(evt_if.valid), 32'd1);
    drain("reprime_drain");
    check_val("reprime_level", 32'(level), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
